// File: rtl/npc_ctrl_pkg.sv
// Shared types and constants for the NPC multi-cycle stage controller.
package npc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET_WAIT,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } npc_state_e;

  localparam logic [1:0] HALT_NONE    = 2'd0;
  localparam logic [1:0] HALT_EBREAK  = 2'd1;
  localparam logic [1:0] HALT_ILLEGAL = 2'd2;
  localparam logic [1:0] HALT_TIMEOUT = 2'd3;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/npc_stage_ctrl_if.sv
// Instruction-fetch handshake between the stage controller (master) and the IFU (slave).
interface npc_stage_ctrl_if;

  logic        ifu_req_o;
  logic        ifu_valid_i;
  logic [31:0] ifu_inst_i;

  modport master (
    output ifu_req_o,
    input  ifu_valid_i,
    input  ifu_inst_i
  );

  modport slave (
    input  ifu_req_o,
    output ifu_valid_i,
    output ifu_inst_i
  );

endinterface

// File: rtl/npc_fetch_watchdog.sv
// Counts consecutive fetch cycles without ifu_valid; flags expiry on the last allowed miss.
module npc_fetch_watchdog #(
  parameter int FETCH_TIMEOUT = 255,
  parameter int TO_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  logic [TO_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + TO_W'(1);
    end
  end

  // The miss that would bring the count to FETCH_TIMEOUT is the one that trips.
  assign o_expired = i_en && (r_count == TO_W'(FETCH_TIMEOUT - 1));

endmodule

// File: rtl/npc_stage_ctrl.sv
// Multi-cycle sequencer: FETCH -> DECODE -> EXEC -> WB, owning PC, IR and halt status.
// Optional perf counters are built when NPC_STAGE_CTRL_PERF_EN is defined.
module npc_stage_ctrl
  import npc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
  parameter int          FETCH_TIMEOUT = 255,
  parameter int          TO_W          = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  npc_stage_ctrl_if.master        ifu,
  output logic [31:0]             pc_o,
  output logic [31:0]             inst_o,
  input  logic                    dec_ebreak_i,
  input  logic                    dec_illegal_i,
  input  logic                    dec_rd_wen_i,
  input  logic [4:0]              dec_rd_i,
  input  logic [31:0]             next_pc_i,
  output logic                    exu_wen_o,
  output logic                    rf_wen_o,
  output logic [4:0]              rf_waddr_o,
  output logic                    halt_o,
  output logic [1:0]              halt_code_o
`ifdef NPC_STAGE_CTRL_PERF_EN
  ,
  output logic [63:0]             perf_cycle_o,
  output logic [63:0]             perf_instret_o
`endif
);

  npc_state_e  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [1:0]  r_halt_code;
  logic        w_in_fetch;
  logic        w_expired;

  assign w_in_fetch = (r_state == ST_FETCH);

  npc_fetch_watchdog #(
    .FETCH_TIMEOUT (FETCH_TIMEOUT),
    .TO_W          (TO_W)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (!w_in_fetch || ifu.ifu_valid_i),
    .i_en      (w_in_fetch && !ifu.ifu_valid_i),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register see pre-edge values, so order here is irrelevant.
    if (!rst) begin
      r_state     <= ST_RESET_WAIT;
      r_pc        <= RESET_PC;
      r_inst      <= '0;
      r_halt_code <= HALT_NONE;
    end else begin
      case (r_state)
        ST_RESET_WAIT: r_state <= ST_FETCH;
        ST_FETCH: begin
          if (ifu.ifu_valid_i) begin
            r_inst  <= ifu.ifu_inst_i;
            r_state <= ST_DECODE;
          end else if (w_expired) begin
            r_halt_code <= HALT_TIMEOUT;
            r_state     <= ST_HALT;
          end
        end
        ST_DECODE: begin
          if (dec_ebreak_i) begin
            r_halt_code <= HALT_EBREAK;
            r_state     <= ST_HALT;
          end else if (dec_illegal_i) begin
            r_halt_code <= HALT_ILLEGAL;
            r_state     <= ST_HALT;
          end else begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: r_state <= ST_WB;
        ST_WB: begin
          r_pc    <= next_pc_i;
          r_state <= ST_FETCH;
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_RESET_WAIT;
      endcase
    end
  end

  // Strobes are qualified with rst so a reset cycle can never issue a partial write.
  assign ifu.ifu_req_o = rst && w_in_fetch;
  assign exu_wen_o     = rst && (r_state == ST_EXEC);
  assign rf_wen_o      = rst && (r_state == ST_WB) && dec_rd_wen_i && (dec_rd_i != 5'd0);
  assign rf_waddr_o    = (rst && (r_state == ST_WB)) ? dec_rd_i : 5'd0;
  assign pc_o          = r_pc;
  assign inst_o        = r_inst;
  assign halt_o        = (r_state == ST_HALT);
  assign halt_code_o   = r_halt_code;

`ifdef NPC_STAGE_CTRL_PERF_EN
  logic [63:0] r_perf_cycle;
  logic [63:0] r_perf_instret;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_cycle   <= '0;
      r_perf_instret <= '0;
    end else begin
      if (r_state != ST_HALT) r_perf_cycle <= r_perf_cycle + 64'd1;
      if (r_state == ST_WB)   r_perf_instret <= r_perf_instret + 64'd1;
    end
  end

  assign perf_cycle_o   = r_perf_cycle;
  assign perf_instret_o = r_perf_instret;
`endif

endmodule

// File: doc/npc_stage_ctrl.md
Name: npc_stage_ctrl

Overview:
- Multi-cycle sequencer for the single-issue NPC core.
- Drives fetch request, instruction-register latch, EXU result-register enable, register-file write enable and PC update, one instruction at a time.
- Sits between IFU (instruction memory handshake), IDU decode flags and EXU/RegFile.
- Owns the PC register, halt/trap status and fetch-timeout watchdog.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded at reset.
- FETCH_TIMEOUT, 255, max cycles waiting for ifu_valid_i before fault halt (≥1).
- TO_W, 8, width of timeout counter; must hold FETCH_TIMEOUT.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-low (0 = reset).
- ifu_req_o  out  1  fetch request; held high until accepted.
- ifu_valid_i  in  1  fetch data valid; accepted when ifu_req_o=1.
- ifu_inst_i  in  32  fetched instruction.
- pc_o  out  32  current PC (fetch address).
- inst_o  out  32  latched instruction register to IDU.
- dec_ebreak_i  in  1  IDU: inst_o is ebreak.
- dec_illegal_i  in  1  IDU: inst_o unsupported.
- dec_rd_wen_i  in  1  IDU: instruction writes rd.
- dec_rd_i  in  5  IDU: destination register.
- next_pc_i  in  32  next PC from EXU/branch logic (pc+4 for non-branch).
- exu_wen_o  out  1  one-cycle enable for EXU result register.
- rf_wen_o  out  1  one-cycle RegFile write enable.
- rf_waddr_o  out  5  RegFile write address.
- halt_o  out  1  core halted (sticky until reset).
- halt_code_o  out  2  0 none, 1 ebreak, 2 illegal, 3 fetch timeout.

Behaviour:
- States: RESET_WAIT, FETCH, DECODE, EXEC, WB, HALT. Encoding is internal.
- Reset (rst=0 at posedge):
  - state=RESET_WAIT, pc_o=RESET_PC, inst_o=0, timeout counter=0.
  - halt_o=0, halt_code_o=0; ifu_req_o, exu_wen_o, rf_wen_o=0; rf_waddr_o=0.
- RESET_WAIT: one cycle, then FETCH.
- FETCH:
  - ifu_req_o=1 combinationally.
  - ifu_valid_i=1 in the same cycle: latch inst_o<=ifu_inst_i, clear counter, go DECODE. Zero-wait memory is legal.
  - Else counter++. When counter reaches FETCH_TIMEOUT: HALT, halt_code=3.
  - ifu_valid_i while not in FETCH is ignored.
- DECODE: one cycle; decode flags sampled here only.
  - ebreak has priority over illegal: HALT, code 1.
  - illegal: HALT, code 2.
  - Else EXEC.
- EXEC: exu_wen_o=1 for exactly this cycle; go WB.
- WB:
  - rf_wen_o=dec_rd_wen_i & (dec_rd_i≠0).
  - rf_waddr_o=dec_rd_i.
  - pc_o<=next_pc_i at clock edge; go FETCH.
- Latency: minimum 4 cycles per instruction (FETCH, DECODE, EXEC, WB) with zero-wait fetch.
- HALT:
  - Absorbing; all enables 0, ifu_req_o=0.
  - pc_o and inst_o hold the trapping instruction.
  - Exit only by reset.
- Reset mid-operation: any state returns to RESET_WAIT next edge. No partial write: enables are 0 during reset.
- pc_o is updated only in WB. next_pc_i is taken verbatim; no alignment check.
- exu_wen_o and rf_wen_o are never high in the same cycle.

Optional Feature:
- Macro NPC_STAGE_CTRL_PERF_EN.
- Defined:
  - Adds outputs perf_cycle_o[63:0] and perf_instret_o[63:0].
  - perf_cycle_o increments every cycle while not HALT and not in reset.
  - perf_instret_o increments on each WB cycle.
  - Both reset to 0, wrap modulo 2^64.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package npc_ctrl_pkg:
  - state enum.
  - halt code constants HALT_NONE/EBREAK/ILLEGAL/TIMEOUT.
  - RESET_PC default.
- One natural sub-module: npc_fetch_watchdog (timeout counter with clear/enable/expired).
- FSM and PC/IR registers stay in the top module.

Test Plan:
- Reset then zero-wait fetch of addi x1,x0,5 (0x00500093), rd_wen=1, rd=1, next_pc=0x80000004:
  - ifu_req in cycle 1.
  - exu_wen pulse cycle 3.
  - rf_wen=1, waddr=1 cycle 4.
  - pc_o=0x80000004 cycle 5.
- Fetch with ifu_valid delayed 10 cycles: ifu_req held 11 cycles, inst_o latched once, no timeout.
- ifu_valid never asserted, FETCH_TIMEOUT=4: halt_o=1, code=3 after 4 FETCH cycles; pc_o=RESET_PC; no enables ever pulse.
- dec_ebreak_i=1 and dec_illegal_i=1 in DECODE: halt code=1, exu_wen never pulses; later ifu_valid ignored.
- rd_wen=1 with rd=0: exu_wen pulses, rf_wen stays 0, pc still advances.
- rst=0 asserted during EXEC: next cycle all outputs at reset values, pc_o=RESET_PC; with PERF_EN, counters read 0.
